// File: rtl/emitter_axis_arbiter.sv
// rtl/emitter_axis_arbiter.sv - packet-atomic round-robin AXI-stream arbiter for the shared emitter
//
// Merges N byte streams into one stream. A granted source keeps the grant
// until its tlast beat is accepted, so packets never interleave. The merged
// stream is driven from a single output register; only o_tready is
// combinational.
//
// Optional build macro: EMITTER_ARB_STATS_EN adds o_pkt_cnt and o_stall.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_tdata  [N*DW]     source data, source k at [k*DW +: DW]
//   i_tlast  [N]        per-source end of packet
//   i_tvalid [N]        per-source valid
//   o_tready [N]        per-source ready, at most one bit high
//   o_tdata  [DW]       merged data
//   o_tlast             merged last
//   o_tvalid            merged valid
//   i_tready            downstream ready
//   o_grant  [IW]       current or most recent granted source
//   o_busy              high while a packet is locked
//   o_pkt_cnt [16]      (stats build) packets accepted, wrapping
//   o_stall             (stats build) granted source idle during a lock

module emitter_axis_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N*DW-1:0] i_tdata,
  input  logic [N-1:0]    i_tlast,
  input  logic [N-1:0]    i_tvalid,
  output logic [N-1:0]    o_tready,
  output logic [DW-1:0]   o_tdata,
  output logic            o_tlast,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [IW-1:0]   o_grant,
  output logic            o_busy
`ifdef EMITTER_ARB_STATS_EN
  ,
  output logic [15:0]     o_pkt_cnt,
  output logic            o_stall
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] ptr;

  logic          free;
  logic          accept;
  logic          sel_tvalid;
  logic          sel_tlast;
  logic [DW-1:0] sel_tdata;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_next;

  // The output register can take a beat when empty or draining this cycle.
  assign free = !o_tvalid || i_tready;

  always_comb begin
    sel_tvalid = i_tvalid[o_grant];
    sel_tlast  = i_tlast[o_grant];
    sel_tdata  = i_tdata[int'(o_grant) * DW +: DW];
  end

  assign accept = (state == LOCK) && sel_tvalid && free;

  always_comb begin
    o_tready = '0;
    if (state == LOCK && !i_rst) begin
      o_tready[o_grant] = free;
    end
  end

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && i_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign ptr_next = (o_grant == IW'(N - 1)) ? '0 : o_grant + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      o_grant  <= '0;
      o_busy   <= 1'b0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
`ifdef EMITTER_ARB_STATS_EN
      o_pkt_cnt <= '0;
      o_stall   <= 1'b0;
`endif
    end else begin
      // Load wins over drain so a packet streams at one beat per cycle.
      if (accept) begin
        o_tdata  <= sel_tdata;
        o_tlast  <= sel_tlast;
        o_tvalid <= 1'b1;
      end else if (i_tready) begin
        o_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            o_grant <= pick;
            o_busy  <= 1'b1;
            state   <= LOCK;
          end
        end
        LOCK: begin
          // No timeout: an idle granted source holds the lock.
          if (accept && sel_tlast) begin
            ptr    <= ptr_next;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef EMITTER_ARB_STATS_EN
      if (accept && sel_tlast) begin
        o_pkt_cnt <= o_pkt_cnt + 16'd1;
      end
      o_stall <= (state == LOCK) && !sel_tvalid;
`else
      // statistics disabled: no counters
`endif
    end
  end

endmodule

// File: tb/tb_emitter_axis_arbiter.sv
// tb/tb_emitter_axis_arbiter.sv - scoreboard bench for emitter_axis_arbiter

module tb_emitter_axis_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] i_tdata;
  logic [N-1:0]  i_tlast;
  logic [N-1:0]  i_tvalid;
  logic [N-1:0]  o_tready;
  logic [DW-1:0] o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          i_tready;
  logic [1:0]    o_grant;
  logic          o_busy;
`ifdef EMITTER_ARB_STATS_EN
  logic [15:0]   o_pkt_cnt;
  logic          o_stall;
`endif

  emitter_axis_arbiter #(.N(N), .DW(DW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready),
    .o_grant  (o_grant),
    .o_busy   (o_busy)
`ifdef EMITTER_ARB_STATS_EN
    ,
    .o_pkt_cnt(o_pkt_cnt),
    .o_stall  (o_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;
  logic [N-1:0] hold = '0;
  int total  = 0;
  int passed = 0;

  task automatic src_pkt(input int k, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) src_q[k].push_back({(b == n - 1), base + 8'(b)});
  endtask

  task automatic exp_pkt(input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({(b == n - 1), base + 8'(b)});
  endtask

  // Source model: handshake observed mid-cycle, next beat presented after the edge.
  initial begin
    logic [N-1:0] hs;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = i_tvalid & o_tready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          i_tvalid[k] = !hold[k];
          i_tdata[k*DW +: DW] = src_q[k][0][7:0];
          i_tlast[k] = src_q[k][0][8];
        end else begin
          i_tvalid[k] = 1'b0;
          i_tlast[k] = 1'b0;
          i_tdata[k*DW +: DW] = '0;
        end
      end
    end
  end

  // Scoreboard: every beat taken downstream must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && o_tvalid && i_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_beat: got tlast=%0d tdata=%02h, expected no beat", o_tlast, o_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_tlast, o_tdata} !== mon_e)
          $display("FAIL out_beat: got tlast=%0d tdata=%02h, expected tlast=%0d tdata=%02h",
                   o_tlast, o_tdata, mon_e[8], mon_e[7:0]);
        else passed++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({o_tvalid, o_tlast, o_busy} !== 3'b000) $display("FAIL reset_flags: got %b, expected 000", {o_tvalid, o_tlast, o_busy});
    else passed++;
    total++;
    if (o_tdata !== 8'h00 || o_grant !== 2'd0) $display("FAIL reset_data_grant: got %02h/%0d, expected 00/0", o_tdata, o_grant);
    else passed++;
    total++;
    if (o_tready !== 4'b0000) $display("FAIL reset_tready: got %b, expected 0000", o_tready);
    else passed++;
`ifdef EMITTER_ARB_STATS_EN
    total++;
    if (o_pkt_cnt !== 16'd0 || o_stall !== 1'b0) $display("FAIL reset_stats: got %0d/%0d, expected 0/0", o_pkt_cnt, o_stall);
    else passed++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    src_pkt(2, 8'h41, 3);
    exp_pkt(8'h41, 3);
    for (int c = 0; c < 50 && !o_tvalid; c++) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      total++;
      if (o_tvalid !== 1'b1 || o_tdata !== 8'h41 + 8'(b) || o_tlast !== (b == 2))
        $display("FAIL single_seq: beat %0d got v=%0d d=%02h l=%0d, expected v=1 d=%02h l=%0d",
                 b, o_tvalid, o_tdata, o_tlast, 8'h41 + 8'(b), (b == 2));
      else passed++;
      @(negedge clk);
    end
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || o_grant !== 2'd2 || o_busy !== 1'b0)
      $display("FAIL single_end: got left=%0d grant=%0d busy=%0d, expected 0/2/0", exp_q.size(), o_grant, o_busy);
    else passed++;
  endtask

  task automatic test_wrap_skip();
    src_pkt(1, 8'h10, 2);
    exp_pkt(8'h10, 2);
    for (int c = 0; c < 50 && !o_busy; c++) @(negedge clk);
    total++;
    if (o_grant !== 2'd1 || o_busy !== 1'b1) $display("FAIL wrap_grant: got %0d busy=%0d, expected 1 busy=1", o_grant, o_busy);
    else passed++;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) @(negedge clk);
    // ptr is now 2: source 2 must beat source 1.
    src_pkt(1, 8'h18, 1);
    src_pkt(2, 8'h28, 1);
    exp_pkt(8'h28, 1);
    exp_pkt(8'h18, 1);
    for (int c = 0; c < 50 && !o_busy; c++) @(negedge clk);
    total++;
    if (o_grant !== 2'd2) $display("FAIL wrap_ptr: got grant %0d, expected 2", o_grant);
    else passed++;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d beats left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_round_robin();
    int gexp [5] = '{0, 1, 2, 3, 0};
    int gi = 0;
    int idle = 0;
    logic prev_busy = 1'b0;
    logic started = 1'b0;
    src_pkt(0, 8'h00, 2);
    src_pkt(0, 8'h08, 2);
    src_pkt(1, 8'h10, 2);
    src_pkt(2, 8'h20, 2);
    src_pkt(3, 8'h30, 2);
    exp_pkt(8'h00, 2);
    exp_pkt(8'h10, 2);
    exp_pkt(8'h20, 2);
    exp_pkt(8'h30, 2);
    exp_pkt(8'h08, 2);
    for (int c = 0; c < 200 && (gi < 5 || o_busy); c++) begin
      @(negedge clk);
      if (o_busy && !prev_busy && gi < 5) begin
        total++;
        if (o_grant !== 2'(gexp[gi])) $display("FAIL rr_order: packet %0d got grant %0d, expected %0d", gi, o_grant, gexp[gi]);
        else passed++;
        gi++;
      end
      if (!o_busy && started && gi < 5) idle++;
      started = started | o_busy;
      prev_busy = o_busy;
    end
    total++;
    if (gi != 5 || idle != 4) $display("FAIL rr_gaps: got grants=%0d idle=%0d, expected 5/4", gi, idle);
    else passed++;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_tvalid); c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d beats left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    src_pkt(3, 8'h50, 6);
    exp_pkt(8'h50, 6);
    for (int c = 0; c < 50 && !o_tvalid; c++) @(negedge clk);
    @(posedge clk); #1; i_tready = 1'b0;
    @(negedge clk);
    held = o_tdata;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (o_tvalid !== 1'b1 || o_tdata !== held || o_tready !== 4'b0000)
        $display("FAIL bp_hold: cycle %0d got v=%0d d=%02h rdy=%b, expected v=1 d=%02h rdy=0000",
                 i, o_tvalid, o_tdata, o_tready, held);
      else passed++;
    end
    @(posedge clk); #1; i_tready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d beats left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_stall();
    int stalls = 0;
`ifdef EMITTER_ARB_STATS_EN
    logic [15:0] cnt0 = o_pkt_cnt;
`endif
    src_pkt(1, 8'h60, 4);
    exp_pkt(8'h60, 4);
    for (int c = 0; c < 50 && !(o_busy && o_grant == 2'd1); c++) @(negedge clk);
    src_pkt(0, 8'h70, 1);
    exp_pkt(8'h70, 1);
    for (int c = 0; c < 50 && !o_tvalid; c++) @(negedge clk);
    hold[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef EMITTER_ARB_STATS_EN
      if (o_stall) stalls++;
`endif
      total++;
      if (o_tready[0] !== 1'b0 || o_grant !== 2'd1 || o_busy !== 1'b1)
        $display("FAIL stall_lock: cycle %0d got rdy0=%0d grant=%0d busy=%0d, expected 0/1/1",
                 i, o_tready[0], o_grant, o_busy);
      else passed++;
    end
    hold[1] = 1'b0;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) begin
      @(negedge clk);
`ifdef EMITTER_ARB_STATS_EN
      if (o_stall) stalls++;
`endif
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d beats left, expected 0", exp_q.size());
    else passed++;
`ifdef EMITTER_ARB_STATS_EN
    total++;
    if (stalls != 10) $display("FAIL stall_count: got %0d, expected 10", stalls);
    else passed++;
    total++;
    if (o_pkt_cnt !== cnt0 + 16'd2) $display("FAIL pkt_cnt: got %0d, expected %0d", o_pkt_cnt, cnt0 + 16'd2);
    else passed++;
`else
    total++;
    if (stalls != 0) $display("FAIL stall_count: got %0d, expected 0", stalls);
    else passed++;
`endif
  endtask

  task automatic test_async_reset();
    src_pkt(2, 8'h80, 5);
    exp_pkt(8'h80, 5);
    for (int c = 0; c < 50 && !o_tvalid; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (o_tvalid !== 1'b0 || o_tready !== 4'b0000 || o_busy !== 1'b0 || o_grant !== 2'd0)
      $display("FAIL areset_now: got v=%0d rdy=%b busy=%0d grant=%0d, expected 0/0000/0/0",
               o_tvalid, o_tready, o_busy, o_grant);
    else passed++;
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    src_pkt(3, 8'h90, 1);
    src_pkt(0, 8'hA0, 1);
    exp_pkt(8'hA0, 1);
    exp_pkt(8'h90, 1);
    for (int c = 0; c < 50 && !o_busy; c++) @(negedge clk);
    total++;
    if (o_grant !== 2'd0 || o_busy !== 1'b1) $display("FAIL areset_grant: got %0d busy=%0d, expected 0 busy=1", o_grant, o_busy);
    else passed++;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || o_busy || o_tvalid); c++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL areset_drain: got %0d beats left, expected 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    i_tready = 1'b1;
    test_reset();
    test_single();
    test_wrap_skip();
    do_reset();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
